lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
- Load/store unit between the execute stage's memory-control outputs (MemWr, MemRd, MemOp, ALU address, store data) and a word-addressed data SRAM port with a valid/ready handshake.
- Handles byte-lane alignment, write strobes, load sign/zero extension and misalignment detection.
- Holds one transaction at a time and asserts busy so the pipeline stalls while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a load or store.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (busB).
- req_memop  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal memop, or timeout; valid with resp_valid.
- busy  out  1  state != IDLE; drives the pipeline stall.
- mem_req_valid  out  1  SRAM request valid.
- mem_req_ready  in  1  SRAM accepts the request.
- mem_addr  out  32  word-aligned address: {req_addr[31:2], 2'b00}.
- mem_wen  out  1  write enable.
- mem_wstrb  out  4  byte strobes.
- mem_wdata  out  32  lane-replicated store data.
- mem_resp_valid  in  1  SRAM read data valid or write acknowledge.
- mem_rdata  in  32  SRAM read word.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state = IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_valid latches addr, wdata, memop and wr.
  - Illegal memop or misalignment goes directly to RESP with err = 1; no memory access is made.
  - Otherwise go to REQ.
- Legality rules:
  - Loads accept 000, 001, 010, 100, 101.
  - Stores accept 000, 001, 010.
  - H/HU requires addr[0] = 0; W requires addr[1:0] = 0.
- REQ:
  - mem_req_valid = 1; mem_addr, mem_wen, mem_wstrb, mem_wdata are held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, capture mem_rdata and go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. No backpressure.
- Minimum latency: accept at cycle N, resp_valid at N+3 when mem_req_ready and mem_resp_valid are both held high. Error path: resp_valid at N+1.
- Strobes:
  - SB: 4'b0001 << a[1:0]
  - SH: 4'b0011 << a[1:0]
  - SW: 4'b1111
  - mem_wstrb = 0 for loads.
- Write data: SB replicates the byte 4x; SH replicates the halfword 2x; SW passes through.
- Load data: shift mem_rdata right by a[1:0]*8, then:
  - B: sign-extend bit 7.
  - BU: zero-extend.
  - H: sign-extend bit 15.
  - HU: zero-extend.
  - W: pass through.
- mem_resp_valid outside WAIT is ignored.
- mem_req_ready outside REQ is ignored.
- req_valid while busy is ignored; the request is not queued.
- rst mid-operation:
  - Return to IDLE on the next edge; the outstanding transaction is dropped and no resp_valid is produced.
  - A late mem_resp_valid after reset is ignored.
- Address wrap: 0xFFFFFFFC word access is legal; no carry handling is needed.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and counts each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with resp_err = 1 and resp_rdata = 0.
  - A mem_resp_valid in the same cycle as the timeout takes priority, giving a normal completion.
- Undefined: no counter; REQ and WAIT can stall indefinitely.

Test Plan:
- Load byte, sign: addr 0x80000003, memop 000, mem_rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80, err 0.
- Load byte, unsigned: memop 100, same data -> resp_rdata 0x00000080.
- Store half: addr 0x80000002, memop 001, wdata 0x0000BEEF -> mem_wstrb 4'b1100, mem_wdata 0xBEEFBEEF, mem_addr 0x80000000.
- Misaligned word: load at 0x80000006 -> no mem_req_valid, resp_valid 1 cycle after accept, err 1, rdata 0.
- Handshake stall: mem_req_ready low for 5 cycles -> request fields held stable, busy = 1 throughout; rst asserted in WAIT -> IDLE, req_ready = 1, no resp_valid.
- Timeout (LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 10): mem_resp_valid never asserted -> resp_valid with err 1 after 10 cycles in REQ/WAIT.

Source files
------------

// File: rtl/lsu_mem_bridge_if.sv
// Execute-stage request/response and data-SRAM port signals of the load/store bridge.
interface lsu_mem_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wr;
    logic [DATA_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [2:0]              req_memop;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;
    logic                    busy;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic                    mem_wen;
    logic [3:0]              mem_wstrb;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_resp_valid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_memop,
               mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_memop,
               mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding load/store bridge to a word-addressed SRAM: lane alignment, strobes, load extension.
// Optional REQ/WAIT watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_bridge #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mem_bridge_if.slave    lsu_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]             r_state;
    logic [DATA_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [2:0]             r_memop;
    logic                   r_wr;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err;

    logic                   w_legal;
    logic                   w_timeout;
    logic [DATA_WIDTH-1:0]  w_shifted;
    logic [DATA_WIDTH-1:0]  w_load;
    logic [DATA_WIDTH-1:0]  w_store_data;
    logic [3:0]             w_strb;

    // Legality is judged on the incoming request so illegal accesses never reach the SRAM.
    always_comb begin
        w_legal = 1'b0;
        case (lsu_bus.req_memop)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~lsu_bus.req_addr[0];
            3'b010:  w_legal = (lsu_bus.req_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~lsu_bus.req_wr;
            3'b101:  w_legal = ~lsu_bus.req_wr & ~lsu_bus.req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    assign w_shifted = lsu_bus.mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_memop)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_store_data = r_wdata;
        w_strb       = 4'b0000;
        if (r_wr) begin
            case (r_memop[1:0])
                2'b00: begin
                    w_store_data = {4{r_wdata[7:0]}};
                    w_strb       = 4'b0001 << r_addr[1:0];
                end
                2'b01: begin
                    w_store_data = {2{r_wdata[15:0]}};
                    w_strb       = 4'b0011 << r_addr[1:0];
                end
                default: begin
                    w_store_data = r_wdata;
                    w_strb       = 4'b1111;
                end
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] r_tcnt;

    // Idle holds the counter at zero, so it starts from zero on every entry to REQ.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_tcnt <= '0;
        end else if (r_state == S_REQ || r_state == S_WAIT) begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end

    assign w_timeout = (r_state == S_REQ || r_state == S_WAIT) && (r_tcnt == TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_memop <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu_bus.req_valid) begin
                        r_addr  <= lsu_bus.req_addr;
                        r_wdata <= lsu_bus.req_wdata;
                        r_memop <= lsu_bus.req_memop;
                        r_wr    <= lsu_bus.req_wr;
                        r_rdata <= '0;
                        r_err   <= ~w_legal;
                        r_state <= w_legal ? S_REQ : S_RESP;
                    end
                end
                S_REQ: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (lsu_bus.mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still completes normally.
                    if (lsu_bus.mem_resp_valid) begin
                        r_rdata <= r_wr ? '0 : w_load;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_bus.req_ready     = (r_state == S_IDLE);
    assign lsu_bus.busy          = (r_state != S_IDLE);
    assign lsu_bus.resp_valid    = (r_state == S_RESP);
    assign lsu_bus.resp_rdata    = (r_state == S_RESP) ? r_rdata : '0;
    assign lsu_bus.resp_err      = (r_state == S_RESP) & r_err;
    assign lsu_bus.mem_req_valid = (r_state == S_REQ);
    assign lsu_bus.mem_addr      = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign lsu_bus.mem_wen       = (r_state == S_REQ) & r_wr;
    assign lsu_bus.mem_wstrb     = (r_state == S_REQ) ? w_strb : 4'b0000;
    assign lsu_bus.mem_wdata     = w_store_data;
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed self-checking bench for lsu_mem_bridge: loads, stores, errors, stall, reset, wrap, timeout.
module tb_lsu_mem_bridge;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    lsu_mem_bridge_if #(.DATA_WIDTH(32)) bus ();

    lsu_mem_bridge #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lsu_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] memop);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_memop = memop;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Cycles counted from the accepting edge; returns one cycle past the response.
    task automatic wait_resp(output int unsigned cyc, output logic [31:0] rdata,
                             output logic err, output bit seen, output logic after);
        cyc   = 1;
        seen  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        after = 1'b0;
        while (!seen && cyc <= 40) begin
            if (bus.resp_valid) begin
                seen  = 1'b1;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (seen) begin
            @(posedge clk);
            #1;
            after = bus.resp_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err, bus.mem_req_valid, bus.mem_wen} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=100000",
                     {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err, bus.mem_req_valid, bus.mem_wen});
        end
        checks++;
        if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%h/%h/%b required=0",
                     bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_ext();
        logic [31:0] addr_t [8] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002,
                                    32'h80000000, 32'h80000001, 32'h80000000, 32'h80000001};
        logic [2:0]  op_t   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b100};
        logic [31:0] exp_t  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                    32'h80FF1234, 32'h00000012, 32'h00001234, 32'h00000012};
        int unsigned cyc;
        logic [31:0] rd;
        logic        er;
        bit          seen;
        logic        after;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h80FF1234;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, addr_t[i], 32'h0, op_t[i]);
            checks++;
            if ({bus.mem_req_valid, bus.mem_wen, bus.mem_wstrb} !== 6'b100000 || bus.mem_addr !== 32'h80000000) begin
                failures++;
                $display("FAIL load_req[%0d] actual=%b addr=%h required=100000 addr=80000000",
                         i, {bus.mem_req_valid, bus.mem_wen, bus.mem_wstrb}, bus.mem_addr);
            end
            wait_resp(cyc, rd, er, seen, after);
            checks++;
            if (!seen || cyc != 3 || rd !== exp_t[i] || er !== 1'b0 || after !== 1'b0) begin
                failures++;
                $display("FAIL load_resp[%0d] actual seen=%0d cyc=%0d rdata=%h err=%b after=%b required seen=1 cyc=3 rdata=%h err=0 after=0",
                         i, seen, cyc, rd, er, after, exp_t[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] addr_t [5] = '{32'h80000002, 32'h80000001, 32'h80000008, 32'h80000000, 32'h80000003};
        logic [2:0]  op_t   [5] = '{3'b001, 3'b000, 3'b010, 3'b001, 3'b000};
        logic [31:0] wd_t   [5] = '{32'h0000BEEF, 32'h123456AB, 32'hDEADBEEF, 32'hFFFF5A5A, 32'h000000C3};
        logic [3:0]  strb_t [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011, 4'b1000};
        logic [31:0] mwd_t  [5] = '{32'hBEEFBEEF, 32'hABABABAB, 32'hDEADBEEF, 32'h5A5A5A5A, 32'hC3C3C3C3};
        logic [31:0] ma_t   [5] = '{32'h80000000, 32'h80000000, 32'h80000008, 32'h80000000, 32'h80000000};
        int unsigned cyc;
        logic [31:0] rd;
        logic        er;
        bit          seen;
        logic        after;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, addr_t[i], wd_t[i], op_t[i]);
            checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_wen !== 1'b1 || bus.mem_wstrb !== strb_t[i] ||
                bus.mem_wdata !== mwd_t[i] || bus.mem_addr !== ma_t[i]) begin
                failures++;
                $display("FAIL store_req[%0d] actual v=%b wen=%b strb=%b wdata=%h addr=%h required v=1 wen=1 strb=%b wdata=%h addr=%h",
                         i, bus.mem_req_valid, bus.mem_wen, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr,
                         strb_t[i], mwd_t[i], ma_t[i]);
            end
            wait_resp(cyc, rd, er, seen, after);
            checks++;
            if (!seen || cyc != 3 || rd !== 32'h0 || er !== 1'b0) begin
                failures++;
                $display("FAIL store_resp[%0d] actual seen=%0d cyc=%0d rdata=%h err=%b required seen=1 cyc=3 rdata=0 err=0",
                         i, seen, cyc, rd, er);
            end
        end
    endtask

    task automatic test_errors();
        logic        wr_t   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] addr_t [8] = '{32'h80000006, 32'h80000001, 32'h80000003, 32'h80000000,
                                    32'h80000000, 32'h80000000, 32'h80000000, 32'h80000002};
        logic [2:0]  op_t   [8] = '{3'b010, 3'b001, 3'b101, 3'b100, 3'b101, 3'b011, 3'b110, 3'b010};
        int unsigned cyc;
        logic [31:0] rd;
        logic        er;
        bit          seen;
        logic        after;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            issue(wr_t[i], addr_t[i], 32'hA5A5A5A5, op_t[i]);
            checks++;
            if (bus.mem_req_valid !== 1'b0 || bus.mem_wen !== 1'b0 || bus.mem_wstrb !== 4'b0000) begin
                failures++;
                $display("FAIL err_nomem[%0d] actual v=%b wen=%b strb=%b required v=0 wen=0 strb=0000",
                         i, bus.mem_req_valid, bus.mem_wen, bus.mem_wstrb);
            end
            wait_resp(cyc, rd, er, seen, after);
            checks++;
            if (!seen || cyc != 1 || rd !== 32'h0 || er !== 1'b1 || after !== 1'b0) begin
                failures++;
                $display("FAIL err_resp[%0d] actual seen=%0d cyc=%0d rdata=%h err=%b after=%b required seen=1 cyc=1 rdata=0 err=1 after=0",
                         i, seen, cyc, rd, er, after);
            end
        end
    endtask

    task automatic test_stall_reset();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        issue(1'b1, 32'h00000010, 32'hCAFEF00D, 3'b010);
        // A second request while busy must be ignored entirely.
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h00000044;
        bus.req_memop = 3'b000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.mem_req_valid, bus.busy, bus.req_ready, bus.mem_wen, bus.mem_wstrb} !== 8'b1101_1111 ||
                bus.mem_addr !== 32'h00000010 || bus.mem_wdata !== 32'hCAFEF00D || bus.resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall[%0d] actual flags=%b addr=%h wdata=%h rv=%b required flags=11011111 addr=00000010 wdata=cafef00d rv=0",
                         i, {bus.mem_req_valid, bus.busy, bus.req_ready, bus.mem_wen, bus.mem_wstrb},
                         bus.mem_addr, bus.mem_wdata, bus.resp_valid);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.mem_req_valid, bus.busy, bus.req_ready, bus.resp_valid} !== 4'b0100) begin
                failures++;
                $display("FAIL wait[%0d] actual=%b required=0100", i,
                         {bus.mem_req_valid, bus.busy, bus.req_ready, bus.resp_valid});
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.req_ready, bus.busy, bus.resp_valid, bus.mem_req_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid actual=%b required=1000",
                     {bus.req_ready, bus.busy, bus.resp_valid, bus.mem_req_valid});
        end
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.req_ready, bus.busy, bus.resp_valid} !== 3'b100) begin
                failures++;
                $display("FAIL late_resp[%0d] actual=%b required=100", i,
                         {bus.req_ready, bus.busy, bus.resp_valid});
            end
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned cyc;
        logic [31:0] rd;
        logic        er;
        bit          seen;
        logic        after;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h7F00C0DE;
        issue(1'b0, 32'h00000100, 32'h0, 3'b010);
        wait_resp(cyc, rd, er, seen, after);
        checks++;
        if (!seen || cyc != 3 || rd !== 32'h7F00C0DE || er !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first actual seen=%0d cyc=%0d rdata=%h err=%b required seen=1 cyc=3 rdata=7f00c0de err=0",
                     seen, cyc, rd, er);
        end
        issue(1'b0, 32'h00000101, 32'h0, 3'b000);
        wait_resp(cyc, rd, er, seen, after);
        checks++;
        if (!seen || cyc != 3 || rd !== 32'hFFFFFFC0 || er !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second actual seen=%0d cyc=%0d rdata=%h err=%b required seen=1 cyc=3 rdata=ffffffc0 err=0",
                     seen, cyc, rd, er);
        end
    endtask

    task automatic test_wrap();
        int unsigned cyc;
        logic [31:0] rd;
        logic        er;
        bit          seen;
        logic        after;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h01234567;
        issue(1'b0, 32'hFFFFFFFC, 32'h0, 3'b010);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'hFFFFFFFC) begin
            failures++;
            $display("FAIL wrap_req actual v=%b addr=%h required v=1 addr=fffffffc",
                     bus.mem_req_valid, bus.mem_addr);
        end
        wait_resp(cyc, rd, er, seen, after);
        checks++;
        if (!seen || rd !== 32'h01234567 || er !== 1'b0) begin
            failures++;
            $display("FAIL wrap_resp actual seen=%0d rdata=%h err=%b required seen=1 rdata=01234567 err=0",
                     seen, rd, er);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned cyc;
        logic [31:0] rd;
        logic        er;
        bit          seen;
        logic        after;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h55555555;
        issue(1'b0, 32'h00000200, 32'h0, 3'b010);
        wait_resp(cyc, rd, er, seen, after);
        checks++;
        if (!seen || cyc != 11 || rd !== 32'h0 || er !== 1'b1) begin
            failures++;
            $display("FAIL timeout actual seen=%0d cyc=%0d rdata=%h err=%b required seen=1 cyc=11 rdata=0 err=1",
                     seen, cyc, rd, er);
        end
    endtask
`endif

    initial begin
        checks             = 0;
        failures           = 0;
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_wr         = 1'b0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.req_memop      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        test_reset();
        test_load_ext();
        test_store();
        test_errors();
        test_stall_reset();
        test_back_to_back();
        test_wrap();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
